// File: rtl/bus_decoder_ctrl.sv
// Registered address decoder: maps one master request onto N_SLAVES base/mask windows, waits for slave ready.
// Latency: 1 cycle to response on unmapped addresses, 2 + slave wait cycles on a hit (capped by TIMEOUT).
// Backpressure: one request in flight; req_i is only sampled in IDLE and ignored while busy_o is high.
module bus_decoder_ctrl #(
    parameter int N_SLAVES = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE =
        {32'h70000000, 32'h60000000, 32'h50000000, 32'h80000000},
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK =
        {32'hFFFFF000, 32'hFFFFF000, 32'hFFFFF000, 32'hE0000000},
    parameter int TIMEOUT  = 15
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       req_i,
    input  logic                       we_i,
    input  logic [ADDR_W-1:0]          addr_i,
    input  logic [DATA_W-1:0]          wdata_i,
    output logic [DATA_W-1:0]          rdata_o,
    output logic                       rvalid_o,
    output logic                       err_o,
    output logic                       busy_o,
    output logic [N_SLAVES-1:0]        en_o,
    output logic                       we_o,
    output logic [ADDR_W-1:0]          addr_o,
    output logic [DATA_W-1:0]          wdata_o,
    input  logic [N_SLAVES*DATA_W-1:0] slv_rdata_i,
    input  logic [N_SLAVES-1:0]        slv_ready_i
);

    localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               err_q;

    logic               hit;
    logic [SEL_W-1:0]   hit_idx;
    logic               sel_ready;
    logic [DATA_W-1:0]  sel_rdata;
    logic               req_ld;
    logic               rsp_ld;
    logic               rsp_err;
    logic [DATA_W-1:0]  rsp_dat;

    // Descending scan so the lowest matching channel is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((addr_i & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ready = slv_ready_i[i];
                sel_rdata = slv_rdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_ld  = 1'b0;
        rsp_ld  = 1'b0;
        rsp_err = 1'b0;
        rsp_dat = '0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    req_ld = 1'b1;
                    if (hit) begin
                        state_d = ACCESS;
                        cnt_d   = '0;
                    end else begin
                        state_d = RESP;
                        rsp_ld  = 1'b1;
                        rsp_err = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // Ready is checked before the timeout so a last-cycle ready still completes cleanly.
                if (sel_ready) begin
                    state_d = RESP;
                    rsp_ld  = 1'b1;
                    rsp_dat = we_q ? '0 : sel_rdata;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    rsp_ld  = 1'b1;
                    rsp_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (req_ld) begin
                sel_q   <= hit_idx;
                we_q    <= we_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end
            if (rsp_ld) begin
                rdata_q <= rsp_dat;
                err_q   <= rsp_err;
            end
        end
    end

    // Enable decoded from registered state so an async reset drops it without a clock.
    always_comb begin
        en_o = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            en_o[i] = (state_q == ACCESS) && (sel_q == SEL_W'(i));
        end
    end

    assign rvalid_o = (state_q == RESP);
    assign busy_o   = (state_q != IDLE);
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;
    assign we_o     = we_q;
    assign addr_o   = addr_q;
    assign wdata_o  = wdata_q;

endmodule

// File: tb/tb_bus_decoder_ctrl.sv
// Directed bench for bus_decoder_ctrl: hits, waits, unmapped, timeout, busy requests and mid-access reset.
module tb_bus_decoder_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         req_i;
    logic         we_i;
    logic [31:0]  addr_i;
    logic [31:0]  wdata_i;
    logic [31:0]  rdata_o;
    logic         rvalid_o;
    logic         err_o;
    logic         busy_o;
    logic [3:0]   en_o;
    logic         we_o;
    logic [31:0]  addr_o;
    logic [31:0]  wdata_o;
    logic [127:0] slv_rdata_i;
    logic [3:0]   slv_ready_i;

    int tests = 0;
    int fails = 0;

    // Results of the last transaction driven by txn().
    int          r_lat;
    int          r_en_cycles;
    logic [3:0]  r_en_seen;
    bit          r_hot_bad;
    bit          r_done;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic [31:0] unmapped [3];

    bus_decoder_ctrl dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .rvalid_o    (rvalid_o),
        .err_o       (err_o),
        .busy_o      (busy_o),
        .en_o        (en_o),
        .we_o        (we_o),
        .addr_o      (addr_o),
        .wdata_o     (wdata_o),
        .slv_rdata_i (slv_rdata_i),
        .slv_ready_i (slv_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    // Issues one request from IDLE and acts as the selected slave, asserting its ready
    // after wait_n enabled cycles; extra is ready held on other channels throughout.
    task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input int wait_n, input logic [3:0] extra, input bit pulse);
        r_lat = 0; r_en_cycles = 0; r_en_seen = '0; r_hot_bad = 0; r_done = 0;
        r_rdata = 'x; r_err = 'x; r_we = 'x; r_addr = 'x; r_wdata = 'x;
        we_i = we; addr_i = a; wdata_i = wd; req_i = 1'b1; slv_ready_i = extra;
        for (int k = 0; k < 40; k++) begin
            step;
            r_lat++;
            if (r_lat == 1) req_i = 1'b0;
            if (rvalid_o) begin
                r_done  = 1;
                r_rdata = rdata_o;
                r_err   = err_o;
                if (en_o != 4'b0) r_hot_bad = 1;
                break;
            end
            if (en_o != 4'b0) begin
                r_en_cycles++;
                r_en_seen |= en_o;
                if ($countones(en_o) != 1) r_hot_bad = 1;
                if (r_en_cycles == 1) begin
                    r_we = we_o; r_addr = addr_o; r_wdata = wdata_o;
                end
                slv_ready_i = extra | ((r_en_cycles > wait_n) ? en_o : 4'b0);
            end
            if (pulse && r_en_cycles == 2) req_i = 1'b1;
            if (pulse && r_en_cycles == 3) req_i = 1'b0;
        end
        slv_ready_i = '0;
    endtask

    initial begin
        rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        slv_ready_i = '0;
        slv_rdata_i = {32'hCAFEF00D, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
        unmapped[0] = 32'h50001000;
        unmapped[1] = 32'hA0000000;
        unmapped[2] = 32'hFFFFFFFF;

        #3;
        chk("rst_en", en_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_we", we_o, 0);
        chk("rst_addr", addr_o, 0);
        chk("rst_wdata", wdata_o, 0);
        step;
        rst_ni = 1'b1;
        step;

        // 1: ch0 read, ready immediately
        txn(1'b0, 32'h80C03010, 32'h0, 0, 4'b0000, 0);
        chk("t1_done", r_done, 1);
        chk("t1_lat", r_lat, 2);
        chk("t1_en_cycles", r_en_cycles, 1);
        chk("t1_en_seen", r_en_seen, 4'b0001);
        chk("t1_addr_o", r_addr, 32'h80C03010);
        chk("t1_rdata", r_rdata, 32'hDEADBEEF);
        chk("t1_err", r_err, 0);
        step;
        chk("t1_rvalid_drop", rvalid_o, 0);
        chk("t1_busy_idle", busy_o, 0);
        chk("t1_rdata_held", rdata_o, 32'hDEADBEEF);

        // 2: ch1 write, three wait cycles
        txn(1'b1, 32'h50000FFF, 32'h12345678, 3, 4'b0000, 0);
        chk("t2_done", r_done, 1);
        chk("t2_lat", r_lat, 5);
        chk("t2_en_cycles", r_en_cycles, 4);
        chk("t2_en_seen", r_en_seen, 4'b0010);
        chk("t2_we_o", r_we, 1);
        chk("t2_wdata_o", r_wdata, 32'h12345678);
        chk("t2_addr_o", r_addr, 32'h50000FFF);
        chk("t2_err", r_err, 0);
        chk("t2_rdata", r_rdata, 0);
        step;

        // 3: unmapped addresses
        for (int u = 0; u < 3; u++) begin
            txn(1'b0, unmapped[u], 32'h0, 0, 4'b0000, 0);
            chk("t3_done", r_done, 1);
            chk("t3_lat", r_lat, 1);
            chk("t3_en_cycles", r_en_cycles, 0);
            chk("t3_err", r_err, 1);
            chk("t3_rdata", r_rdata, 0);
            chk("t3_onehot", r_hot_bad, 0);
            step;
            chk("t3_busy_idle", busy_o, 0);
        end

        // 4: ch3 never ready, ch2 ready held high and must be ignored
        txn(1'b0, 32'h70000FAB, 32'h0, 99, 4'b0100, 0);
        chk("t4_done", r_done, 1);
        chk("t4_en_cycles", r_en_cycles, 15);
        chk("t4_en_seen", r_en_seen, 4'b1000);
        chk("t4_lat", r_lat, 16);
        chk("t4_err", r_err, 1);
        chk("t4_rdata", r_rdata, 0);
        chk("t4_onehot", r_hot_bad, 0);
        step;

        // 5: ch2 ready on the final ACCESS cycle, request pulsed while busy
        txn(1'b0, 32'h60000A11, 32'h0, 14, 4'b0000, 1);
        chk("t5_done", r_done, 1);
        chk("t5_en_cycles", r_en_cycles, 15);
        chk("t5_en_seen", r_en_seen, 4'b0100);
        chk("t5_lat", r_lat, 16);
        chk("t5_err", r_err, 0);
        chk("t5_rdata", r_rdata, 32'h22222222);
        for (int s = 0; s < 3; s++) begin
            step;
            chk("t5_no_extra_busy", busy_o, 0);
            chk("t5_no_extra_en", en_o, 0);
        end

        // 6: reset in the middle of an access
        we_i = 1'b0; addr_i = 32'h9FFFFFFF; req_i = 1'b1;
        step;
        req_i = 1'b0;
        chk("t6_en_access", en_o, 4'b0001);
        chk("t6_busy_access", busy_o, 1);
        step;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_en", en_o, 0);
        chk("t6_rst_busy", busy_o, 0);
        chk("t6_rst_rvalid", rvalid_o, 0);
        chk("t6_rst_addr", addr_o, 0);
        step;
        rst_ni = 1'b1;
        step;
        chk("t6_idle_rvalid", rvalid_o, 0);
        slv_rdata_i[31:0] = 32'h13572468;
        txn(1'b0, 32'h81111111, 32'h0, 1, 4'b0000, 0);
        chk("t6_done", r_done, 1);
        chk("t6_lat", r_lat, 3);
        chk("t6_en_seen", r_en_seen, 4'b0001);
        chk("t6_err", r_err, 0);
        chk("t6_rdata", r_rdata, 32'h13572468);
        step;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
